// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
// Stage 1 captures the operand beat; stage 2 computes and registers the
// result together with the carry, compare and zero flags. Both stages advance
// together, so a stalled output holds the whole pipe.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       select,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             compare,
  output logic             zero
);

  logic             advance;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [3:0]       s1_sel;
  logic             s1_mode;
  logic             s2_valid;

  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_carry;

  // The pipe moves whenever the output register is empty or being drained.
  assign advance   = !s2_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = s2_valid;

  // Stage 1: capture the operand beat; data regs need no reset since s1_valid gates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_cin   <= carry_in;
      s1_sel   <= select;
      s1_mode  <= mode;
    end
  end

  // Stage 2 datapath: logic ops directly, arithmetic as X + Y + cin at WIDTH+1 bits.
  always_comb begin
    op_x      = '0;
    op_y      = '0;
    sum       = '0;
    res       = '0;
    res_carry = 1'b0;
    if (s1_mode) begin
      case (s1_sel)
        4'b0000: res = ~s1_a;
        4'b0001: res = ~(s1_a | s1_b);
        4'b0010: res = ~s1_a & s1_b;
        4'b0011: res = '0;
        4'b0100: res = ~(s1_a & s1_b);
        4'b0101: res = ~s1_b;
        4'b0110: res = s1_a ^ s1_b;
        4'b0111: res = s1_a & ~s1_b;
        4'b1000: res = ~s1_a | s1_b;
        4'b1001: res = ~(s1_a ^ s1_b);
        4'b1010: res = s1_b;
        4'b1011: res = s1_a & s1_b;
        4'b1100: res = '1;
        4'b1101: res = s1_a | ~s1_b;
        4'b1110: res = s1_a | s1_b;
        default: res = s1_a;
      endcase
    end else begin
      case (s1_sel)
        4'b0000: begin op_x = s1_a;          op_y = '0;            end
        4'b0001: begin op_x = s1_a | s1_b;   op_y = '0;            end
        4'b0010: begin op_x = s1_a | ~s1_b;  op_y = '0;            end
        4'b0011: begin op_x = '0;            op_y = '1;            end
        4'b0100: begin op_x = s1_a;          op_y = s1_a & ~s1_b;  end
        4'b0101: begin op_x = s1_a | s1_b;   op_y = s1_a & ~s1_b;  end
        4'b0110: begin op_x = s1_a;          op_y = ~s1_b;         end
        4'b0111: begin op_x = s1_a & ~s1_b;  op_y = '1;            end
        4'b1000: begin op_x = s1_a;          op_y = s1_a & s1_b;   end
        4'b1001: begin op_x = s1_a;          op_y = s1_b;          end
        4'b1010: begin op_x = s1_a | ~s1_b;  op_y = s1_a & s1_b;   end
        4'b1011: begin op_x = s1_a & s1_b;   op_y = '1;            end
        4'b1100: begin op_x = s1_a;          op_y = s1_a;          end
        4'b1101: begin op_x = s1_a | s1_b;   op_y = s1_a;          end
        4'b1110: begin op_x = s1_a | ~s1_b;  op_y = s1_a;          end
        default: begin op_x = s1_a;          op_y = '1;            end
      endcase
      sum       = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, s1_cin};
      res       = sum[WIDTH-1:0];
      res_carry = sum[WIDTH];
    end
  end

  // Stage 2: register result and flags; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      alu_out   <= '0;
      carry_out <= 1'b0;
      compare   <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      s2_valid  <= s1_valid;
      alu_out   <= res;
      carry_out <= res_carry;
      compare   <= (s1_a == s1_b);
      zero      <= (res == '0);
    end
  end

endmodule
